// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg -- shared definitions for the interrupt / HALT / STOP sequencer.
//   seq_state_e   : sequencer FSM states
//   VECTOR_BASE   : address of the lowest-priority-index interrupt vector
//   VECTOR_STRIDE : spacing between consecutive interrupt vectors
//   DISPATCH_LEN  : number of M-cycles in one interrupt dispatch
//   ACK_SLOT      : dispatch M-cycle index carrying the IRQ_ACK pulse
//   IDX_W         : width of an interrupt channel index (up to 24 channels)
//   vec_addr()    : channel index -> vector address
// -----------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_DISPATCH = 3'd1,
      ST_HALT     = 3'd2,
      ST_STOP     = 3'd3,
      ST_SETTLE   = 3'd4
   } seq_state_e;

   localparam logic [7:0]  VECTOR_BASE   = 8'h40;
   localparam logic [7:0]  VECTOR_STRIDE = 8'd8;
   localparam int unsigned DISPATCH_LEN  = 32'd5;
   localparam int unsigned ACK_SLOT      = 32'd3;
   localparam int unsigned IDX_W         = 32'd5;

   // Vector address of interrupt channel idx.
   function automatic logic [7:0] vec_addr(input logic [IDX_W-1:0] idx);
      return VECTOR_BASE + (VECTOR_STRIDE * {3'b000, idx});
   endfunction

endpackage

// File: rtl/seq_prio_enc.sv
// -----------------------------------------------------------------------------
// seq_prio_enc -- lowest-index-wins priority encoder.
//   req    in  N      request vector
//   onehot out N      one-hot of the lowest set bit of req (zero if none)
//   idx    out IDX_W  index of that bit (zero if none)
//   valid  out 1      any bit of req set
// -----------------------------------------------------------------------------
module seq_prio_enc
   import seq_pkg::*;
#(
   parameter int unsigned N = 5
) (
   input  logic [N-1:0]     req,
   output logic [N-1:0]     onehot,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      onehot = '0;
      idx    = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            idx       = IDX_W'(i);
         end else begin
            onehot = onehot;
         end
      end
   end

   assign valid = |req;

endmodule

// File: rtl/seq_irq_halt.sv
// -----------------------------------------------------------------------------
// seq_irq_halt -- interrupt dispatch, IME control, HALT and STOP sequencer.
//   CLK, nRESET                 M-cycle clock, async active-low reset
//   IRQ_REQ, IRQ_MASK  [N_IRQ]  interrupt flags (IF) and enables (IE)
//   INSN_END                    last M-cycle of the current instruction
//   OP_EI/DI/RETI/HALT/STOP     decoded opcode, qualified by INSN_END
//   WAKE                        external STOP wake
//   IRQ_ACK [N_IRQ]             one-hot pulse clearing the serviced IF bit
//   INT_TAKE, STATE, VECTOR     dispatch active, its M-cycle index, target
//   IME, HALTED, STOPPED        master enable, HALT active, STOP active
//   CLK_ENA, OSC_ENA            CPU clock gate, oscillator enable
// Build option: define SEQ_HALT_BUG_EN to add the HALT_BUG output, pulsed
// when HALT executes with IME=0 and an interrupt already pending.
// N_IRQ legal range is 1..24 (vector addresses must fit in 8 bits).
// -----------------------------------------------------------------------------
module seq_irq_halt
   import seq_pkg::*;
#(
   parameter int unsigned N_IRQ      = 5,
   parameter int unsigned WAKE_CNT_W = 8,
   parameter int unsigned STATE_W    = 3
) (
   input  logic               CLK,
   input  logic               nRESET,
   input  logic [N_IRQ-1:0]   IRQ_REQ,
   input  logic [N_IRQ-1:0]   IRQ_MASK,
   input  logic               INSN_END,
   input  logic               OP_EI,
   input  logic               OP_DI,
   input  logic               OP_RETI,
   input  logic               OP_HALT,
   input  logic               OP_STOP,
   input  logic               WAKE,
   output logic [N_IRQ-1:0]   IRQ_ACK,
   output logic               INT_TAKE,
   output logic [7:0]         VECTOR,
   output logic [STATE_W-1:0] STATE,
   output logic               IME,
   output logic               HALTED,
   output logic               STOPPED,
   output logic               CLK_ENA,
   output logic               OSC_ENA
`ifdef SEQ_HALT_BUG_EN
   ,
   output logic               HALT_BUG
`endif
);

   localparam logic [STATE_W-1:0] LAST_CNT    = STATE_W'(DISPATCH_LEN - 32'd1);
   // The acknowledge is registered one edge ahead so it is visible in ACK_SLOT.
   localparam logic [STATE_W-1:0] PRE_ACK_CNT = STATE_W'(ACK_SLOT - 32'd1);

   seq_state_e              state_r, state_nx_s;
   logic                    ime_r, ime_nx_s;
   logic                    ei_arm_r, ei_arm_nx_s;
   logic [STATE_W-1:0]      cnt_r, cnt_nx_s;
   logic [N_IRQ-1:0]        ack_r, ack_nx_s;
   logic [7:0]              vector_r, vector_nx_s;
   logic                    int_take_r, int_take_nx_s;
   logic                    halted_r, halted_nx_s;
   logic                    stopped_r, stopped_nx_s;
   logic                    clk_ena_r, clk_ena_nx_s;
   logic                    osc_ena_r, osc_ena_nx_s;
   logic [WAKE_CNT_W-1:0]   wake_cnt_r, wake_cnt_nx_s;
`ifdef SEQ_HALT_BUG_EN
   logic                    halt_bug_r, halt_bug_nx_s;
`endif

   logic [N_IRQ-1:0]        onehot_s;
   logic [IDX_W-1:0]        idx_s;
   logic                    pending_s;
   logic                    dispatch_go_s;

   seq_prio_enc #(.N(N_IRQ)) u_prio (
      .req    (IRQ_REQ & IRQ_MASK),
      .onehot (onehot_s),
      .idx    (idx_s),
      .valid  (pending_s)
   );

   // EI/DI/HALT/STOP at the same boundary suppress the dispatch decision.
   assign dispatch_go_s = ime_r & pending_s & ~(OP_EI | OP_DI | OP_HALT | OP_STOP);

   // Next-state and next-output computation for the whole sequencer.
   always_comb begin
      state_nx_s    = state_r;
      ime_nx_s      = ime_r;
      ei_arm_nx_s   = ei_arm_r;
      cnt_nx_s      = cnt_r;
      ack_nx_s      = '0;
      vector_nx_s   = vector_r;
      int_take_nx_s = int_take_r;
      halted_nx_s   = halted_r;
      stopped_nx_s  = stopped_r;
      clk_ena_nx_s  = clk_ena_r;
      osc_ena_nx_s  = osc_ena_r;
      wake_cnt_nx_s = wake_cnt_r;
`ifdef SEQ_HALT_BUG_EN
      halt_bug_nx_s = 1'b0;
`endif
      case (state_r)
         ST_RUN: begin
            if (INSN_END) begin
               // DI beats both a pending EI and RETI; an armed EI lands now.
               if (OP_DI) begin
                  ime_nx_s    = 1'b0;
                  ei_arm_nx_s = 1'b0;
               end else begin
                  ime_nx_s    = ime_r | ei_arm_r | OP_RETI;
                  ei_arm_nx_s = OP_EI;
               end
               if (OP_STOP) begin
                  state_nx_s   = ST_STOP;
                  stopped_nx_s = 1'b1;
                  clk_ena_nx_s = 1'b0;
                  osc_ena_nx_s = 1'b0;
               end else if (OP_HALT) begin
                  if (!pending_s) begin
                     state_nx_s   = ST_HALT;
                     halted_nx_s  = 1'b1;
                     clk_ena_nx_s = 1'b1;
                  end else begin
                     // Interrupt already pending: HALT falls straight through.
`ifdef SEQ_HALT_BUG_EN
                     halt_bug_nx_s = ~ime_r;
`endif
                     state_nx_s = ST_RUN;
                  end
               end else if (dispatch_go_s) begin
                  state_nx_s    = ST_DISPATCH;
                  cnt_nx_s      = '0;
                  int_take_nx_s = 1'b1;
                  ime_nx_s      = 1'b0;
                  ei_arm_nx_s   = 1'b0;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DISPATCH: begin
            if (cnt_r == LAST_CNT) begin
               state_nx_s    = ST_RUN;
               cnt_nx_s      = '0;
               int_take_nx_s = 1'b0;
            end else begin
               cnt_nx_s = cnt_r + STATE_W'(1);
               if (cnt_r == PRE_ACK_CNT) begin
                  // No pending source left: cancelled dispatch, vector 0x00.
                  ack_nx_s    = onehot_s;
                  vector_nx_s = pending_s ? vec_addr(idx_s) : 8'h00;
               end else begin
                  vector_nx_s = vector_r;
               end
            end
         end
         ST_HALT: begin
            if (pending_s) begin
               halted_nx_s = 1'b0;
               if (ime_r) begin
                  state_nx_s    = ST_DISPATCH;
                  cnt_nx_s      = '0;
                  int_take_nx_s = 1'b1;
                  ime_nx_s      = 1'b0;
                  ei_arm_nx_s   = 1'b0;
               end else begin
                  state_nx_s = ST_RUN;
               end
            end else begin
               state_nx_s = ST_HALT;
            end
         end
         ST_STOP: begin
            if (WAKE) begin
               state_nx_s    = ST_SETTLE;
               osc_ena_nx_s  = 1'b1;
               wake_cnt_nx_s = '0;
            end else begin
               state_nx_s = ST_STOP;
            end
         end
         ST_SETTLE: begin
            // Full counter period of oscillator settle; WAKE is ignored here.
            if (wake_cnt_r == '1) begin
               state_nx_s    = ST_RUN;
               clk_ena_nx_s  = 1'b1;
               stopped_nx_s  = 1'b0;
               wake_cnt_nx_s = '0;
            end else begin
               wake_cnt_nx_s = wake_cnt_r + WAKE_CNT_W'(1);
            end
         end
         default: begin
            state_nx_s    = ST_RUN;
            cnt_nx_s      = '0;
            int_take_nx_s = 1'b0;
            halted_nx_s   = 1'b0;
            stopped_nx_s  = 1'b0;
            clk_ena_nx_s  = 1'b1;
            osc_ena_nx_s  = 1'b1;
         end
      endcase
   end

   // Sequencer state and output registers.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state_r    <= ST_RUN;
         ime_r      <= 1'b0;
         ei_arm_r   <= 1'b0;
         cnt_r      <= '0;
         ack_r      <= '0;
         vector_r   <= 8'h00;
         int_take_r <= 1'b0;
         halted_r   <= 1'b0;
         stopped_r  <= 1'b0;
         clk_ena_r  <= 1'b1;
         osc_ena_r  <= 1'b1;
         wake_cnt_r <= '0;
`ifdef SEQ_HALT_BUG_EN
         halt_bug_r <= 1'b0;
`endif
      end else begin
         state_r    <= state_nx_s;
         ime_r      <= ime_nx_s;
         ei_arm_r   <= ei_arm_nx_s;
         cnt_r      <= cnt_nx_s;
         ack_r      <= ack_nx_s;
         vector_r   <= vector_nx_s;
         int_take_r <= int_take_nx_s;
         halted_r   <= halted_nx_s;
         stopped_r  <= stopped_nx_s;
         clk_ena_r  <= clk_ena_nx_s;
         osc_ena_r  <= osc_ena_nx_s;
         wake_cnt_r <= wake_cnt_nx_s;
`ifdef SEQ_HALT_BUG_EN
         halt_bug_r <= halt_bug_nx_s;
`endif
      end
   end

   assign IRQ_ACK  = ack_r;
   assign INT_TAKE = int_take_r;
   assign VECTOR   = vector_r;
   assign STATE    = cnt_r;
   assign IME      = ime_r;
   assign HALTED   = halted_r;
   assign STOPPED  = stopped_r;
   assign CLK_ENA  = clk_ena_r;
   assign OSC_ENA  = osc_ena_r;
`ifdef SEQ_HALT_BUG_EN
   assign HALT_BUG = halt_bug_r;
`endif

endmodule

// File: doc/seq_irq_halt.md
SEQ_IRQ_HALT -- requirements
Module: seq_irq_halt

Interface
REQ-001 SHALL have parameter N_IRQ, default 5, interrupt channel count, legal range 1..24.
REQ-002 SHALL have parameter WAKE_CNT_W, default 8, width of the oscillator-settle counter used on STOP exit.
REQ-003 SHALL have parameter STATE_W, default 3, width of the dispatch M-cycle counter.
REQ-004 SHALL use one clock and an asynchronous active-low reset, named as below:
- CLK  in  1  M-cycle clock, free-running; all state changes on rising edge.
- nRESET  in  1  asynchronous active-low reset.
- IRQ_REQ  in  N_IRQ  interrupt request flags (IF).
- IRQ_MASK  in  N_IRQ  interrupt enable mask (IE).
- INSN_END  in  1  last M-cycle of the current instruction; opcode strobes are qualified by it.
- OP_EI, OP_DI, OP_RETI, OP_HALT, OP_STOP  in  1 each  decoded opcode of the ending instruction.
- WAKE  in  1  external STOP wake (joypad).
- IRQ_ACK  out  N_IRQ  one-hot acknowledge pulse that clears the serviced IF bit.
- INT_TAKE  out  1  high for every dispatch M-cycle.
- VECTOR  out  8  dispatch target address.
- STATE  out  STATE_W  dispatch M-cycle index 0..4.
- IME, HALTED, STOPPED  out  1 each  interrupt master enable; HALT active; STOP active.
- CLK_ENA, OSC_ENA  out  1 each  CPU clock gate; oscillator enable.

Function
REQ-005 SHALL define pending = OR(IRQ_REQ & IRQ_MASK).
REQ-006 SHALL implement FSM states RUN, DISPATCH, HALT, STOP, SETTLE.
REQ-007 In RUN at INSN_END with IME=1, pending=1, and none of OP_EI/OP_DI/OP_HALT/OP_STOP: SHALL enter DISPATCH, STATE=0, and clear IME the same edge.
REQ-008 DISPATCH SHALL last exactly 5 cycles, STATE 0..4, then return to RUN; INT_TAKE=1 throughout.
REQ-009 In the STATE=3 cycle, SHALL select the lowest-index set bit of IRQ_REQ & IRQ_MASK, pulse IRQ_ACK for that cycle only, and register VECTOR=0x40+8*index on that edge, valid through STATE=4.
REQ-010 If pending=0 at STATE=3: SHALL emit no IRQ_ACK and set VECTOR=0x00 (cancelled dispatch).
REQ-011 OP_DI at INSN_END: SHALL clear IME on that edge; it wins over any simultaneous dispatch condition.
REQ-012 OP_EI at INSN_END: SHALL arm a one-instruction delay; IME=1 only at the next INSN_END edge; no dispatch at EI's own INSN_END.
REQ-013 OP_DI at the INSN_END following EI: SHALL cancel the armed EI, leaving IME=0.
REQ-014 OP_RETI at INSN_END: SHALL set IME=1 on that edge; dispatch is allowed at the next INSN_END.
REQ-015 OP_HALT at INSN_END with pending=0: SHALL enter HALT, HALTED=1, CLK_ENA=1.
REQ-016 In HALT, when pending=1: SHALL enter DISPATCH if IME=1, else RUN; HALTED drops the same edge.
REQ-017 OP_STOP at INSN_END: SHALL enter STOP with STOPPED=1, CLK_ENA=0, and OSC_ENA=0 on the next edge.
REQ-018 In STOP, WAKE=1: SHALL enter SETTLE with OSC_ENA=1 and clear the counter.
REQ-019 SETTLE SHALL count 2^WAKE_CNT_W cycles, wrapping to 0, then enter RUN with CLK_ENA=1 and STOPPED=0; WAKE toggling during SETTLE has no effect.
REQ-020 INSN_END and opcode strobes SHALL be ignored outside RUN.

Reset
REQ-021 nRESET low SHALL asynchronously force:
- state RUN; IME=0; EI delay disarmed;
- IRQ_ACK=0, INT_TAKE=0, VECTOR=0x00, STATE=0, HALTED=0, STOPPED=0;
- CLK_ENA=1, OSC_ENA=1.
REQ-022 Reset during DISPATCH, HALT, STOP or SETTLE SHALL abort the sequence without issuing IRQ_ACK.

Configuration
REQ-023 Macro SEQ_HALT_BUG_EN defined: OP_HALT at INSN_END with IME=0 and pending=1 SHALL stay in RUN and pulse output HALT_BUG for one cycle, so the fetch unit repeats the PC increment.
REQ-024 Macro undefined: HALT_BUG port absent; the same case SHALL stay in RUN with no side effect.

Structure
REQ-025 Package seq_pkg SHALL hold the FSM state enum, VECTOR_BASE=8'h40, VECTOR_STRIDE=8, and DISPATCH_LEN=5.
REQ-026 Sub-module seq_prio_enc (N_IRQ-wide lowest-index priority encoder giving one-hot and index) SHALL be instantiated once.

Verification
REQ-027 Bench SHALL cover:
- IME=1, IRQ_REQ=IRQ_MASK=5'b00110, INSN_END -> 5 INT_TAKE cycles, IRQ_ACK=5'b00010 at STATE=3, VECTOR=0x48, IME=0.
- EI, then INSN_END with pending -> no dispatch; the next INSN_END sets IME and dispatch starts one INSN_END later.
- HALT with IME=0, then IRQ_REQ[4]=1 with mask set -> HALTED falls, state RUN, no IRQ_ACK.
- Dispatch with IRQ_REQ cleared during STATE=1 -> IRQ_ACK=0, VECTOR=0x00.
- STOP, then WAKE, WAKE_CNT_W=4 -> OSC_ENA=1 immediately; CLK_ENA=1 after exactly 16 cycles.
- nRESET low at STATE=2 -> all outputs at reset values asynchronously; SEQ_HALT_BUG_EN build: HALT with IME=0 and pending -> one HALT_BUG pulse.
